// File: rtl/pll_reset_seq.sv
// ---------------------------------------------------------------------------
// pll_reset_seq
//   Reset sequencer for the 27 MHz -> 135 MHz video PLL. Runs on the 27 MHz
//   reference clock, pulses the PLL reset, filters the asynchronous lock
//   output and releases the system reset once lock has been stable long
//   enough. Lock loss or lock timeout re-pulses the PLL and bumps a
//   saturating retry counter.
//
// Ports
//   clk        in   27 MHz reference clock (also feeds the PLL)
//   rst_n      in   asynchronous active-low reset
//   pll_lock   in   PLL lock, asynchronous to clk
//   pll_reset  out  active-high PLL reset
//   sys_rst_n  out  active-low system reset, synchronous to clk
//   locked     out  high while in RUN
//   retry_cnt  out  saturating count of PLL re-pulses after the first
//   state_o    out  current state (0 PLL_RST, 1 WAIT_LOCK, 2 RUN)
// ---------------------------------------------------------------------------
module pll_reset_seq #(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int LOSS_FILTER    = 4,
    parameter int CNT_W          = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       locked,
    output logic [3:0] retry_cnt,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] L_RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_LOSS_LAST   = CNT_W'(LOSS_FILTER - 1);

    state_t           r_state, w_state_nxt;
    // r_cnt: cycles in the current state (pulse length / lock timeout).
    // r_sub: stable-lock run length in WAIT_LOCK, lock-loss run length in RUN.
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_sub, w_sub_nxt;
    logic [3:0]       r_retry, w_retry_nxt;
    logic             w_retry_inc;
    logic             r_sync1, r_lock_s;
    logic             r_pll_reset, r_sys_rst_n, r_locked;

    // Two-flop synchronizer for the asynchronous lock output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= pll_lock;
            r_lock_s <= r_sync1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_sub_nxt   = r_sub;
        w_retry_inc = 1'b0;
        case (r_state)
            PLL_RST: begin
                if (r_cnt == L_RST_LAST) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_sub_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                w_sub_nxt = r_lock_s ? r_sub + 1'b1 : '0;
                // Reaching stable lock takes priority over the timeout.
                if (r_lock_s && (r_sub == L_STABLE_LAST)) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                    w_sub_nxt   = '0;
                end else if (r_cnt == L_TO_LAST) begin
                    w_state_nxt = PLL_RST;
                    w_cnt_nxt   = '0;
                    w_sub_nxt   = '0;
                    w_retry_inc = 1'b1;
                end
            end
            RUN: begin
                w_cnt_nxt = r_cnt;
                w_sub_nxt = r_lock_s ? '0 : r_sub + 1'b1;
                if (!r_lock_s && (r_sub == L_LOSS_LAST)) begin
                    w_state_nxt = PLL_RST;
                    w_cnt_nxt   = '0;
                    w_sub_nxt   = '0;
                    w_retry_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = PLL_RST;
                w_cnt_nxt   = '0;
                w_sub_nxt   = '0;
            end
        endcase
        w_retry_nxt = (w_retry_inc && (r_retry != 4'hF)) ? r_retry + 4'd1 : r_retry;
    end

    // Outputs are registered from the next state so they switch on the
    // same edge as the state register, with no decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PLL_RST;
            r_cnt       <= '0;
            r_sub       <= '0;
            r_retry     <= 4'd0;
            r_pll_reset <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sub       <= w_sub_nxt;
            r_retry     <= w_retry_nxt;
            r_pll_reset <= (w_state_nxt == PLL_RST);
            r_sys_rst_n <= (w_state_nxt == RUN);
            r_locked    <= (w_state_nxt == RUN);
        end
    end

    assign pll_reset = r_pll_reset;
    assign sys_rst_n = r_sys_rst_n;
    assign locked    = r_locked;
    assign retry_cnt = r_retry;
    assign state_o   = r_state;

endmodule

// File: tb/tb_pll_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_seq
//   Directed bench for pll_reset_seq with RST=4, STABLE=8, TIMEOUT=32,
//   LOSS=3. Expected values are queued as stimulus is applied and popped
//   when the corresponding DUT observation is taken.
// ---------------------------------------------------------------------------
module tb_pll_reset_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       pll_reset, sys_rst_n, locked;
    logic [3:0] retry_cnt;
    logic [1:0] state_o;

    pll_reset_seq #(
        .RST_CYCLES    (4),
        .STABLE_CYCLES (8),
        .TIMEOUT_CYCLES(32),
        .LOSS_FILTER   (3),
        .CNT_W         (17)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .sys_rst_n(sys_rst_n),
        .locked   (locked),
        .retry_cnt(retry_cnt),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input int obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty: observed %0d with no expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_bad++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
            end
        end
    endtask

    function automatic int sig(input int sel);
        case (sel)
            0:       return int'(pll_reset);
            1:       return int'(sys_rst_n);
            default: return int'(state_o);
        endcase
    endfunction

    // Count clock cycles while the selected output holds value v (bounded).
    task automatic count_while(input int sel, input int v, output int n);
        n = 0;
        while (sig(sel) == v && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic check_reset_state(input string pfx);
        push({pfx, "_state"}, 0);     check(int'(state_o));
        push({pfx, "_pll_reset"}, 1); check(int'(pll_reset));
        push({pfx, "_sys_rst_n"}, 0); check(int'(sys_rst_n));
        push({pfx, "_locked"}, 0);    check(int'(locked));
        push({pfx, "_retry"}, 0);     check(int'(retry_cnt));
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        tick(); tick();
        check_reset_state("reset");

        // Clean lock
        rst_n = 1'b1;
        push("clean_rst_pulse", 4);
        count_while(0, 1, n); check(n);
        repeat (10) tick();
        pll_lock = 1'b1;
        push("clean_lock_to_release", 10);
        count_while(1, 0, n); check(n);
        push("clean_state", 2);     check(int'(state_o));
        push("clean_locked", 1);    check(int'(locked));
        push("clean_retry", 0);     check(int'(retry_cnt));
        push("clean_pll_reset", 0); check(int'(pll_reset));

        // Glitch shorter than the loss filter
        pll_lock = 1'b0;
        tick(); tick();
        pll_lock = 1'b1;
        repeat (6) tick();
        push("glitch_state", 2);     check(int'(state_o));
        push("glitch_sys_rst_n", 1); check(int'(sys_rst_n));

        // Real lock loss
        pll_lock = 1'b0;
        push("loss_latency", 5);
        count_while(1, 1, n); check(n);
        push("loss_state", 0);     check(int'(state_o));
        push("loss_pll_reset", 1); check(int'(pll_reset));
        push("loss_locked", 0);    check(int'(locked));
        push("loss_retry", 1);     check(int'(retry_cnt));
        push("loss_rst_pulse", 4);
        count_while(0, 1, n); check(n);

        // Stable-count restart: high 5, low 1, high 8
        pll_lock = 1'b1;
        repeat (5) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        push("restart_still_wait", 1); check(int'(state_o));
        push("restart_to_release", 10);
        count_while(1, 0, n); check(n);
        push("restart_state", 2); check(int'(state_o));
        push("restart_retry", 1); check(int'(retry_cnt));

        // Asynchronous reset between clock edges while in RUN
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("async");
        tick();

        // Timeout retries with lock held low
        pll_lock = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push("timeout_rst_pulse", 4);
            count_while(0, 1, n); check(n);
            push("timeout_wait_len", 32);
            count_while(0, 0, n); check(n);
            push("timeout_retry", (i + 1 > 15) ? 15 : i + 1);
            check(int'(retry_cnt));
            push("timeout_sys_rst_n", 0); check(int'(sys_rst_n));
        end

        // Tie: stable count completes on the timeout cycle
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        push("tie_rst_pulse", 4);
        count_while(0, 1, n); check(n);
        repeat (22) tick();
        pll_lock = 1'b1;
        push("tie_cycles_in_wait", 10);
        count_while(2, 1, n); check(n);
        push("tie_state", 2);     check(int'(state_o));
        push("tie_retry", 0);     check(int'(retry_cnt));
        push("tie_sys_rst_n", 1); check(int'(sys_rst_n));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
